hist2d_accum: RTL and testbench

- Parametrised successor to the fixed 8-bit hist2d_count block.
- Accumulates a 2D I/Q histogram of qubit readout points into on-chip RAM.
- Collects exactly num_data_pts strobes, then streams every in-range bin out over a valid/ready interface.
- Adds RAM clear, pipelined read-modify-write with same-bin forwarding, saturating counts, out-of-range drop counting and back-pressured readout.

---
 rtl/hist2d_pkg.sv | 23 ++
 rtl/hist2d_accum_if.sv | 23 ++
 rtl/hist2d_bin_ram.sv | 22 ++
 rtl/hist2d_accum.sv | 193 +++++++++++++++++++
 tb/tb_hist2d_accum.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hist2d_pkg.sv
// Shared definitions for the 2D I/Q histogram accumulator: FSM encodings,
// RAM address width and the saturating bin increment.
package hist2d_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] ACCUM = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] READ  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  function automatic int addr_w(input int i_w, input int q_w);
    return i_w + q_w;
  endfunction

  // Counts wider than 31 bits are not supported by this helper.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/hist2d_accum_if.sv
// Back-pressured readout stream of histogram bins.
interface hist2d_accum_if #(
  parameter int I_W   = 8,
  parameter int Q_W   = 8,
  parameter int CNT_W = 16
);
  logic             data_out;
  logic             out_ready;
  logic [CNT_W-1:0] bin_val;
  logic [I_W-1:0]   i_bin_out;
  logic [Q_W-1:0]   q_bin_out;
  logic             out_last;

  modport master (
    output data_out, bin_val, i_bin_out, q_bin_out, out_last,
    input  out_ready
  );

  modport slave (
    input  data_out, bin_val, i_bin_out, q_bin_out, out_last,
    output out_ready
  );
endinterface

// File: rtl/hist2d_bin_ram.sv
// Simple dual-port bin RAM: one write port, one registered read port.
module hist2d_bin_ram #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Read during write to the same address returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[raddr];
  end

endmodule

// File: rtl/hist2d_accum.sv
// 2D I/Q histogram: clears the bin RAM, accumulates points through a forwarded
// read-modify-write pipeline, then streams in-range bins out.
module hist2d_accum
  import hist2d_pkg::*;
#(
  parameter int I_W    = 8,
  parameter int Q_W    = 8,
  parameter int CNT_W  = 16,
  parameter int NPTS_W = 16
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              start,
  input  logic [NPTS_W-1:0] num_data_pts,
  input  logic [I_W:0]      i_bin_num,
  input  logic [Q_W:0]      q_bin_num,
  input  logic              data_in,
  input  logic [I_W-1:0]    i_bin_coord,
  input  logic [Q_W-1:0]    q_bin_coord,
  output logic              busy,
  hist2d_accum_if.master    rdout,
  output logic [NPTS_W-1:0] dropped_cnt,
  output logic              done
);

  localparam int AW = addr_w(I_W, Q_W);

  logic [2:0]        state;
  logic [NPTS_W-1:0] npts_r, pts_cnt, drop_r;
  logic [I_W:0]      i_num_r;
  logic [Q_W:0]      q_num_r;
  logic [AW-1:0]     clr_addr;

  logic              s1_valid, s2_valid, s1_fwd;
  logic [AW-1:0]     s1_addr, s2_addr;
  logic [CNT_W-1:0]  s1_fwd_data, s2_data, s1_old, s1_new;

  logic [I_W-1:0]    rd_i, nxt_i, out_i;
  logic [Q_W-1:0]    rd_q, nxt_q, out_q;
  logic              rd_first, rd_pend, out_valid, out_last_r;
  logic [CNT_W-1:0]  out_val;

  logic              strobe, in_range, hit, hit_s1, hit_s2;
  logic              fire, q_wrap, i_last, last_bin;
  logic [AW-1:0]     s0_addr, ram_raddr, ram_waddr;
  logic              ram_we;
  logic [CNT_W-1:0]  ram_wdata, ram_rd_data;

  assign strobe   = (state == ACCUM) && data_in;
  assign in_range = ({1'b0, i_bin_coord} < i_num_r) && ({1'b0, q_bin_coord} < q_num_r);
  assign hit      = strobe && in_range;
  assign s0_addr  = {i_bin_coord, q_bin_coord};
  assign hit_s1   = s1_valid && (s1_addr == s0_addr);
  assign hit_s2   = s2_valid && (s2_addr == s0_addr);

  assign s1_old = s1_fwd ? s1_fwd_data : ram_rd_data;
  assign s1_new = CNT_W'(sat_inc(32'(s1_old), CNT_W));

  assign fire     = out_valid && rdout.out_ready;
  assign q_wrap   = ({1'b0, rd_q} + (Q_W+1)'(1)) == q_num_r;
  assign i_last   = ({1'b0, rd_i} + (I_W+1)'(1)) == i_num_r;
  assign last_bin = q_wrap && i_last;
  assign nxt_q    = q_wrap ? '0 : rd_q + Q_W'(1);
  assign nxt_i    = q_wrap ? rd_i + I_W'(1) : rd_i;

  // On an accepted beat the next bin is read at once so the refill takes two cycles.
  assign ram_raddr = (state == READ) ? (fire ? {nxt_i, nxt_q} : {rd_i, rd_q}) : s0_addr;

  always_comb begin
    ram_we    = s2_valid;
    ram_waddr = s2_addr;
    ram_wdata = s2_data;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = '0;
    end
  end

  hist2d_bin_ram #(.AW(AW), .DW(CNT_W)) u_ram (
    .clk     (clk100),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr   (ram_raddr),
    .rd_data (ram_rd_data)
  );

  // The RAM cannot see writes from S1/S2 yet, so the newest value rides along with the read.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_addr     <= '0;
      s1_fwd      <= 1'b0;
      s1_fwd_data <= '0;
      s2_valid    <= 1'b0;
      s2_addr     <= '0;
      s2_data     <= '0;
    end else begin
      s1_valid    <= hit;
      s1_addr     <= s0_addr;
      s1_fwd      <= hit && (hit_s1 || hit_s2);
      s1_fwd_data <= hit_s1 ? s1_new : s2_data;
      s2_valid    <= s1_valid;
      s2_addr     <= s1_addr;
      s2_data     <= s1_new;
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      npts_r     <= '0;
      pts_cnt    <= '0;
      drop_r     <= '0;
      i_num_r    <= '0;
      q_num_r    <= '0;
      clr_addr   <= '0;
      rd_i       <= '0;
      rd_q       <= '0;
      rd_first   <= 1'b0;
      rd_pend    <= 1'b0;
      out_valid  <= 1'b0;
      out_last_r <= 1'b0;
      out_val    <= '0;
      out_i      <= '0;
      out_q      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= CLEAR;
          npts_r   <= num_data_pts;
          i_num_r  <= i_bin_num;
          q_num_r  <= q_bin_num;
          clr_addr <= '0;
          pts_cnt  <= '0;
          drop_r   <= '0;
        end
        CLEAR: begin
          clr_addr <= clr_addr + AW'(1);
          if (&clr_addr) state <= (npts_r == '0) ? DRAIN : ACCUM;
        end
        ACCUM: if (data_in) begin
          pts_cnt <= pts_cnt + NPTS_W'(1);
          if (!in_range) drop_r <= drop_r + NPTS_W'(1);
          if ((pts_cnt + NPTS_W'(1)) == npts_r) state <= DRAIN;
        end
        DRAIN: if (!s1_valid && !s2_valid) begin
          if (i_num_r == '0 || q_num_r == '0) begin
            state <= DONE;
          end else begin
            state    <= READ;
            rd_i     <= '0;
            rd_q     <= '0;
            rd_first <= 1'b1;
          end
        end
        READ: begin
          rd_first <= 1'b0;
          rd_pend  <= rd_first || (fire && !last_bin);
          if (rd_pend) begin
            out_valid  <= 1'b1;
            out_val    <= ram_rd_data;
            out_i      <= rd_i;
            out_q      <= rd_q;
            out_last_r <= last_bin;
          end
          if (fire) begin
            out_valid <= 1'b0;
            if (last_bin) begin
              state <= DONE;
            end else begin
              rd_i <= nxt_i;
              rd_q <= nxt_q;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign dropped_cnt     = drop_r;
  assign rdout.data_out  = out_valid;
  assign rdout.bin_val   = out_val;
  assign rdout.i_bin_out = out_i;
  assign rdout.q_bin_out = out_q;
  assign rdout.out_last  = out_last_r;

endmodule

// File: tb/tb_hist2d_accum.sv
// Scoreboard bench for hist2d_accum: directed runs push expected beats,
// a negedge monitor pops and compares every transferred beat.
module tb_hist2d_accum;

  localparam int I_W    = 4;
  localparam int Q_W    = 4;
  localparam int CNT_W  = 4;
  localparam int NPTS_W = 8;

  typedef struct {
    logic [I_W-1:0]   i;
    logic [Q_W-1:0]   q;
    logic [CNT_W-1:0] val;
    logic             last;
  } beat_t;

  logic              clk100 = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [NPTS_W-1:0] num_data_pts = '0;
  logic [I_W:0]      i_bin_num = '0;
  logic [Q_W:0]      q_bin_num = '0;
  logic              data_in = 1'b0;
  logic [I_W-1:0]    i_bin_coord = '0;
  logic [Q_W-1:0]    q_bin_coord = '0;
  logic              busy, done;
  logic [NPTS_W-1:0] dropped_cnt;

  hist2d_accum_if #(.I_W(I_W), .Q_W(Q_W), .CNT_W(CNT_W)) rd_if ();

  hist2d_accum #(.I_W(I_W), .Q_W(Q_W), .CNT_W(CNT_W), .NPTS_W(NPTS_W)) dut (
    .clk100       (clk100),
    .rst          (rst),
    .start        (start),
    .num_data_pts (num_data_pts),
    .i_bin_num    (i_bin_num),
    .q_bin_num    (q_bin_num),
    .data_in      (data_in),
    .i_bin_coord  (i_bin_coord),
    .q_bin_coord  (q_bin_coord),
    .busy         (busy),
    .rdout        (rd_if.master),
    .dropped_cnt  (dropped_cnt),
    .done         (done)
  );

  always #5 clk100 = ~clk100;

  int    total = 0;
  int    bad = 0;
  int    done_seen = 0;
  bit    toggle_mode = 1'b0;
  beat_t exp_q[$];
  int    exp_hist[16][16];
  int    pt_i[$];
  int    pt_q[$];

  // out_ready changes just after the rising edge so the monitor sees it settled.
  initial begin
    int cnt;
    cnt = 0;
    rd_if.out_ready = 1'b1;
    forever begin
      @(posedge clk100);
      #1;
      if (toggle_mode) begin
        cnt++;
        if (cnt == 3) begin
          cnt = 0;
          rd_if.out_ready = ~rd_if.out_ready;
        end
      end else begin
        rd_if.out_ready = 1'b1;
      end
    end
  end

  // A stalled beat must be presented unchanged on the following cycle.
  initial begin
    bit               prev_stall;
    logic [CNT_W-1:0] pv;
    logic [I_W-1:0]   pi;
    logic [Q_W-1:0]   pq;
    logic             pl;
    beat_t            e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk100);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          total++;
          if (!(rd_if.data_out && rd_if.bin_val == pv && rd_if.i_bin_out == pi &&
                rd_if.q_bin_out == pq && rd_if.out_last == pl)) begin
            bad++;
            $display("[TB] FAIL stall_hold: got valid=%0b val=%0d i=%0d q=%0d last=%0b, want valid=1 val=%0d i=%0d q=%0d last=%0b",
                     rd_if.data_out, rd_if.bin_val, rd_if.i_bin_out, rd_if.q_bin_out, rd_if.out_last, pv, pi, pq, pl);
          end
        end
        if (rd_if.data_out && rd_if.out_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL extra_beat: got beat i=%0d q=%0d val=%0d, want none",
                     rd_if.i_bin_out, rd_if.q_bin_out, rd_if.bin_val);
          end else begin
            e = exp_q.pop_front();
            if (rd_if.bin_val !== e.val || rd_if.i_bin_out !== e.i ||
                rd_if.q_bin_out !== e.q || rd_if.out_last !== e.last) begin
              bad++;
              $display("[TB] FAIL beat: got val=%0d i=%0d q=%0d last=%0b, want val=%0d i=%0d q=%0d last=%0b",
                       rd_if.bin_val, rd_if.i_bin_out, rd_if.q_bin_out, rd_if.out_last, e.val, e.i, e.q, e.last);
            end
          end
        end
        if (done) done_seen++;
        prev_stall = rd_if.data_out && !rd_if.out_ready;
        pv = rd_if.bin_val;
        pi = rd_if.i_bin_out;
        pq = rd_if.q_bin_out;
        pl = rd_if.out_last;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {busy, done, rd_if.data_out, rd_if.out_last, rd_if.bin_val,
                 rd_if.i_bin_out, rd_if.q_bin_out, dropped_cnt}, 64'd0);
  endtask

  task automatic clear_expect();
    for (int i = 0; i < 16; i++)
      for (int q = 0; q < 16; q++) exp_hist[i][q] = 0;
  endtask

  task automatic add_points(input int i, input int q, input int n);
    for (int k = 0; k < n; k++) begin
      pt_i.push_back(i);
      pt_q.push_back(q);
    end
  endtask

  task automatic push_expected(input int ni, input int nq);
    beat_t b;
    for (int i = 0; i < ni; i++)
      for (int q = 0; q < nq; q++) begin
        b.i    = I_W'(i);
        b.q    = Q_W'(q);
        b.val  = CNT_W'(exp_hist[i][q]);
        b.last = (i == ni - 1) && (q == nq - 1);
        exp_q.push_back(b);
      end
  endtask

  task automatic start_run(input int npts, input int ni, input int nq);
    @(negedge clk100);
    num_data_pts = NPTS_W'(npts);
    i_bin_num    = (I_W+1)'(ni);
    q_bin_num    = (Q_W+1)'(nq);
    start        = 1'b1;
    @(negedge clk100);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    repeat (256) @(negedge clk100);
  endtask

  task automatic drive_points();
    while (pt_i.size() > 0) begin
      data_in     = 1'b1;
      i_bin_coord = I_W'(pt_i.pop_front());
      q_bin_coord = Q_W'(pt_q.pop_front());
      @(negedge clk100);
    end
    data_in = 1'b0;
  endtask

  task automatic check_output(input int base, input int exp_drop);
    int waited;
    waited = 0;
    while (done_seen == base && waited < 4000) begin
      @(negedge clk100);
      waited++;
    end
    total++;
    if (done_seen == base) begin
      bad++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles, want done", waited);
    end
    repeat (3) @(negedge clk100);
    check("done_pulses", done_seen - base, 1);
    check("beats_left", exp_q.size(), 0);
    exp_q.delete();
    check("dropped_cnt", dropped_cnt, exp_drop);
    check("busy_idle", busy, 0);
  endtask

  task automatic apply_stimulus(input int npts, input int ni, input int nq, input int exp_drop);
    int base;
    push_expected(ni, nq);
    base = done_seen;
    start_run(npts, ni, nq);
    drive_points();
    check_output(base, exp_drop);
  endtask

  initial begin
    repeat (3) @(negedge clk100);
    check_reset_outputs("reset_outputs");
    rst = 1'b0;
    repeat (2) @(negedge clk100);

    // one bin hit repeatedly; last beat on (9,9)
    clear_expect(); exp_hist[3][4] = 10;
    add_points(3, 4, 10);
    apply_stimulus(10, 10, 10, 0);

    // interleaved back-to-back hits exercise both forwarding stages
    clear_expect(); exp_hist[1][1] = 3; exp_hist[2][2] = 1;
    add_points(1, 1, 2); add_points(2, 2, 1); add_points(1, 1, 1);
    apply_stimulus(4, 4, 4, 0);

    // everything out of range
    clear_expect();
    add_points(15, 15, 10);
    apply_stimulus(10, 10, 10, 10);

    // 20 hits saturate a 4-bit count
    clear_expect(); exp_hist[0][0] = 15;
    add_points(0, 0, 20);
    apply_stimulus(20, 1, 1, 0);

    // back-pressured readout
    toggle_mode = 1'b1;
    clear_expect(); exp_hist[0][0] = 2; exp_hist[9][9] = 1; exp_hist[5][5] = 1;
    add_points(0, 0, 1); add_points(9, 9, 1); add_points(5, 5, 1);
    add_points(0, 0, 1); add_points(10, 2, 1);
    apply_stimulus(5, 10, 10, 1);
    toggle_mode = 1'b0;

    // zero points: straight to readout of cleared bins
    clear_expect();
    apply_stimulus(0, 2, 2, 0);

    // zero I bins: no beats, points dropped
    clear_expect();
    add_points(0, 0, 1); add_points(1, 1, 1);
    apply_stimulus(2, 0, 3, 2);

    // abort mid-accumulation with reset, then rerun
    start_run(50, 10, 10);
    add_points(0, 0, 6); add_points(12, 3, 2);
    drive_points();
    check("dropped_before_abort", dropped_cnt, 2);
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_accum");
    repeat (2) @(negedge clk100);
    check_reset_outputs("reset_held");
    rst = 1'b0;
    repeat (2) @(negedge clk100);
    clear_expect(); exp_hist[0][0] = 5;
    add_points(0, 0, 5);
    apply_stimulus(5, 3, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
